lcd_init_sequencer: RTL and testbench

Drives the HD44780-style LCD through its power-on initialisation sequence on the init-side bus of the LCD output mux. It asserts `init_complete_flag` when done, which hands the LCD bus to the button-driven path. It owns all init timing: power-up wait, E pulse width, and per-command execution gaps. It is idle once complete until a re-init request arrives.

---
 rtl/lcd_init_sequencer_pkg.sv | 37 +++
 rtl/lcd_init_rom.sv | 22 ++
 rtl/lcd_init_sequencer.sv | 138 +++++++++++++
 tb/tb_lcd_init_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lcd_init_sequencer_pkg.sv
// Shared HD44780 definitions: instruction bytes, init sequencer state encoding and helpers.
// The button-driven LCD controller imports the same instruction constants.
package lcd_init_sequencer_pkg;

  localparam logic [7:0] FUNC_SET_8B_2L = 8'h38;
  localparam logic [7:0] DISP_OFF       = 8'h08;
  localparam logic [7:0] CLEAR          = 8'h01;
  localparam logic [7:0] HOME           = 8'h02;
  localparam logic [7:0] ENTRY_INC      = 8'h06;
  localparam logic [7:0] DISP_ON        = 8'h0C;

  localparam int NUM_CMDS = 8;

  typedef enum logic [2:0] {
    ST_POWERUP = 3'd0,
    ST_SETUP   = 3'd1,
    ST_EHIGH   = 3'd2,
    ST_HOLD    = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // Clear and return-home need the long execution time.
  function automatic logic is_long_gap(input logic [7:0] cmd);
    return (cmd == CLEAR) || (cmd == HOME);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/lcd_init_rom.sv
// Combinational init command table: 3-bit index to instruction byte plus long-gap flag.
module lcd_init_rom
  import lcd_init_sequencer_pkg::*;
(
  input  logic [2:0] idx,
  output logic [7:0] cmd,
  output logic       long_gap
);

  always_comb begin
    cmd = DISP_ON;
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: cmd = FUNC_SET_8B_2L;
      3'd4:                   cmd = DISP_OFF;
      3'd5:                   cmd = CLEAR;
      3'd6:                   cmd = ENTRY_INC;
      default:                cmd = DISP_ON;
    endcase
    long_gap = is_long_gap(cmd);
  end

endmodule

// File: rtl/lcd_init_sequencer.sv
// HD44780 power-on init sequencer: power-up wait, then eight E-strobed instructions, then DONE.
// Outputs are registered decodes of the current state, so they trail the state register by one cycle.
//
// state   | meaning
// POWERUP | waiting POWERUP_CYCLES after reset
// SETUP   | one cycle of data setup before E rises
// EHIGH   | E high for E_HIGH_CYCLES
// HOLD    | one cycle of data hold after E falls
// GAP     | instruction execution time (short or long)
// DONE    | sequence finished, bus handed to button path
module lcd_init_sequencer
  import lcd_init_sequencer_pkg::*;
#(
  parameter int POWERUP_CYCLES   = 1_000_000,
  parameter int E_HIGH_CYCLES    = 25,
  parameter int CMD_GAP_CYCLES   = 2_500,
  parameter int CLEAR_GAP_CYCLES = 100_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       reinit,
  output logic [7:0] data_init_lcd,
  output logic       RS_init_lcd,
  output logic       RW_init_lcd,
  output logic       E_init_lcd,
  output logic       init_complete_flag
);

  localparam int MAX_P = max4(POWERUP_CYCLES, E_HIGH_CYCLES, CMD_GAP_CYCLES, CLEAR_GAP_CYCLES);
  localparam int CW    = $clog2(MAX_P) + 1;

  localparam logic [CW-1:0] PU_LAST    = CW'(POWERUP_CYCLES - 1);
  localparam logic [CW-1:0] EH_LAST    = CW'(E_HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(CMD_GAP_CYCLES - 1);
  localparam logic [CW-1:0] CLEAR_LAST = CW'(CLEAR_GAP_CYCLES - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    cmd;
  logic          long_gap;

  logic [7:0]    data_nxt;
  logic          e_nxt;
  logic          flag_nxt;

  lcd_init_rom u_rom (
    .idx      (idx),
    .cmd      (cmd),
    .long_gap (long_gap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= ST_POWERUP;
      cnt                <= '0;
      idx                <= '0;
      data_init_lcd      <= 8'h00;
      RS_init_lcd        <= 1'b0;
      RW_init_lcd        <= 1'b0;
      E_init_lcd         <= 1'b0;
      init_complete_flag <= 1'b0;
    end else begin
      state              <= state_nxt;
      cnt                <= cnt_nxt;
      idx                <= idx_nxt;
      data_init_lcd      <= data_nxt;
      RS_init_lcd        <= 1'b0;
      RW_init_lcd        <= 1'b0;
      E_init_lcd         <= e_nxt;
      init_complete_flag <= flag_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    idx_nxt   = idx;
    data_nxt  = 8'h00;
    e_nxt     = 1'b0;
    flag_nxt  = 1'b0;

    case (state)
      ST_POWERUP: begin
        if (cnt == PU_LAST) begin
          state_nxt = ST_SETUP;
          cnt_nxt   = '0;
          idx_nxt   = '0;
        end
      end
      ST_SETUP: begin
        data_nxt  = cmd;
        state_nxt = ST_EHIGH;
        cnt_nxt   = '0;
      end
      ST_EHIGH: begin
        data_nxt = cmd;
        e_nxt    = 1'b1;
        if (cnt == EH_LAST) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = '0;
        end
      end
      ST_HOLD: begin
        data_nxt  = cmd;
        state_nxt = ST_GAP;
        cnt_nxt   = '0;
      end
      ST_GAP: begin
        data_nxt = cmd;
        if (cnt == (long_gap ? CLEAR_LAST : GAP_LAST)) begin
          cnt_nxt = '0;
          if (idx == 3'(NUM_CMDS - 1)) begin
            state_nxt = ST_DONE;
          end else begin
            idx_nxt   = idx + 3'd1;
            state_nxt = ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        flag_nxt = 1'b1;
        cnt_nxt  = '0;
        // reinit skips the power-up wait; it is only looked at here.
        if (reinit) begin
          state_nxt = ST_SETUP;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_POWERUP;
        cnt_nxt   = '0;
        idx_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Bench for lcd_init_sequencer: timeline model of the expected bus per cycle plus literal timing checks.
module tb_lcd_init_sequencer;

  localparam int PU = 10;
  localparam int EH = 3;
  localparam int CG = 4;
  localparam int LG = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       reinit = 1'b0;
  logic [7:0] data;
  logic       rs, rw, e, flag;

  always #5 clk = ~clk;

  lcd_init_sequencer #(
    .POWERUP_CYCLES   (PU),
    .E_HIGH_CYCLES    (EH),
    .CMD_GAP_CYCLES   (CG),
    .CLEAR_GAP_CYCLES (LG)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .reinit             (reinit),
    .data_init_lcd      (data),
    .RS_init_lcd        (rs),
    .RW_init_lcd        (rw),
    .E_init_lcd         (e),
    .init_complete_flag (flag)
  );

  int n_tests = 0;
  int n_fail  = 0;

  int rel       = -1;
  int seq_start = PU;
  bit armed     = 1'b0;
  int data10    = -1;

  logic [7:0] cmds [8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  int ref_bytes [8]    = '{'h38, 'h38, 'h38, 'h38, 'h08, 'h01, 'h06, 'h0C};

  int rise_q[$], fall_q[$], fbyte_q[$], frise_q[$], ffall_q[$];
  logic prev_e = 1'b0, prev_f = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Expected {data, RS, RW, E, flag} at cycle t of a run whose first SETUP output appears at cycle s.
  function automatic logic [11:0] model_out(input int t, input int s);
    int o, gap, len;
    if (t < s) return 12'h000;
    o = t - s;
    for (int i = 0; i < 8; i++) begin
      gap = (cmds[i] == 8'h01 || cmds[i] == 8'h02) ? LG : CG;
      len = 2 + EH + gap;
      if (o < len) return {cmds[i], 1'b0, 1'b0, (o >= 1 && o <= EH), 1'b0};
      o -= len;
    end
    return {8'h00, 3'b000, 1'b1};
  endfunction

  always @(posedge clk) begin : cmp
    logic        rst_s, ri_s;
    logic [11:0] expv;
    rst_s = rst;
    ri_s  = reinit;
    #1;
    if (rst_s) begin
      armed     = 1'b1;
      rel       = -1;
      seq_start = PU;
    end else if (armed) begin
      rel++;
    end
    if (armed) begin
      expv = rst_s ? 12'h000 : model_out(rel, seq_start);
      check($sformatf("bus@%0d", rel), {20'h0, data, rs, rw, e, flag}, {20'h0, expv});
      if (!rst_s) begin
        if (rel == 10) data10 = int'(data);
        if (e && !prev_e) rise_q.push_back(rel);
        if (!e && prev_e) begin
          fall_q.push_back(rel);
          fbyte_q.push_back(int'(data));
        end
        if (flag && !prev_f) frise_q.push_back(rel);
        if (!flag && prev_f) ffall_q.push_back(rel);
        if (ri_s && expv[0]) seq_start = rel + 1;
      end
      prev_e = e;
      prev_f = flag;
    end
  end

  task automatic wait_until(input int t);
    int n;
    n = 0;
    while (rel < t && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (rel < t) check("wait_timeout", rel, t);
  endtask

  task automatic pulse_at(input int p);
    wait_until(p - 1);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
  endtask

  task automatic clear_q();
    rise_q.delete(); fall_q.delete(); fbyte_q.delete();
    frise_q.delete(); ffall_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_q();
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // First run, with a reinit pulse mid-sequence that must be ignored.
    pulse_at(40);
    wait_until(100);
    check("data_at_10", data10, 'h38);
    check("e_rise_first", qget(rise_q, 0), 11);
    check("e_fall_first", qget(fall_q, 0), 14);
    for (int i = 0; i < 8; i++)
      check($sformatf("byte%0d", i), qget(fbyte_q, i), ref_bytes[i]);
    for (int i = 0; i < 7; i++)
      check($sformatf("gap%0d", i), qget(rise_q, i + 1) - 1 - qget(fall_q, i) - 1, (i == 5) ? 8 : 4);
    check("flag_rise_first", qget(frise_q, 0), 86);
    check("flag_rise_count", frise_q.size(), 1);

    // Single reinit pulse in DONE.
    clear_q();
    pulse_at(110);
    wait_until(195);
    check("reinit_flag_drop", qget(ffall_q, 0), 111);
    check("reinit_e_rise", qget(rise_q, 0), 112);
    check("reinit_flag_rise", qget(frise_q, 0), 187);

    // Reset during EHIGH of command 5.
    do_reset();
    wait_until(56);
    check("e_high_cmd5", e, 1'b1);
    check("data_cmd5", data, 8'h01);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pulse", {data, e, flag}, 10'h000);
    rst = 1'b0;
    clear_q();
    wait_until(95);
    check("rst_restart_rise", qget(rise_q, 0), 11);
    check("rst_restart_flag", qget(frise_q, 0), 86);

    // reinit held high: back-to-back runs with a one-cycle flag between.
    do_reset();
    wait_until(80);
    reinit = 1'b1;
    wait_until(250);
    reinit = 1'b0;
    wait_until(330);
    check("held_rise0", qget(frise_q, 0), 86);
    check("held_rise1", qget(frise_q, 1), 163);
    check("held_rise2", qget(frise_q, 2), 240);
    check("held_rise3", qget(frise_q, 3), 317);
    check("held_fall0", qget(ffall_q, 0), 87);
    check("held_fall1", qget(ffall_q, 1), 164);
    check("held_fall2", qget(ffall_q, 2), 241);
    check("held_fall_count", ffall_q.size(), 3);
    check("held_flag_end", flag, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
